// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving datapath selects and strobes.
// Define MC_CTRL_MEM_WAIT_EN to add the mem_ready port and stretch FETCH/MEM until memory is ready.
module mc_ctrl_fsm #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [31:0] instr,
    input  logic        zero,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic [2:0]  pc_choice,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic [2:0]  rf_wsel,
    output logic [2:0]  rf_dst,
    output logic        dm_re,
    output logic        dm_we,
    output logic [2:0]  state,
    output logic [31:0] retired,
    output logic        illegal
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t      cur, nxt;
    logic [31:0] ir;
    logic [5:0]  op, fn;
    logic        is_op0, is_jr, is_ialu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_ill;
    logic        taken, rdy, go, set_ill, unused_ir;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    assign rdy = 1'b1;
`endif

    assign go        = ena && !rst;
    assign op        = ir[31:26];
    assign fn        = ir[5:0];
    assign unused_ir = ^ir[25:6];
    assign is_op0    = op == 6'h00;
    assign is_jr     = is_op0 && fn == 6'h08;
    assign is_ialu   = op[5:3] == 3'b001;
    assign is_lw     = op == 6'h23;
    assign is_sw     = op == 6'h2B;
    assign is_beq    = op == 6'h04;
    assign is_bne    = op == 6'h05;
    assign is_j      = op == 6'h02;
    assign is_jal    = op == 6'h03;
    assign is_ill    = !(is_op0 || is_ialu || is_lw || is_sw || is_beq || is_bne || is_j || is_jal);
    assign taken     = (is_beq && zero) || (is_bne && !zero);
    assign state     = cur;

    always_comb begin
        nxt       = cur;
        pc_choice = 3'd1;
        rf_wsel   = 3'd1;
        rf_dst    = 3'd1;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        dm_re     = 1'b0;
        dm_we     = 1'b0;
        set_ill   = 1'b0;
        case (cur)
            FETCH: begin
                ir_we = rdy;
                nxt   = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                pc_we     = is_j || is_jr || is_ill;
                pc_choice = is_j ? 3'd3 : is_jr ? 3'd4 : 3'd1;
                set_ill   = is_ill;
                nxt       = pc_we ? FETCH : is_jal ? WB : EXEC;
            end
            EXEC: begin
                pc_we     = is_beq || is_bne;
                pc_choice = taken ? 3'd2 : 3'd1;
                nxt       = pc_we ? FETCH : (is_lw || is_sw) ? MEM : WB;
            end
            MEM: begin
                dm_re = is_lw;
                dm_we = is_sw;
                pc_we = is_sw && rdy;
                nxt   = !rdy ? MEM : is_sw ? FETCH : WB;
            end
            WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                rf_wsel   = is_lw ? 3'd2 : is_jal ? 3'd3 : 3'd1;
                rf_dst    = is_jal ? 3'd3 : (is_ialu || is_lw) ? 3'd2 : 3'd1;
                pc_choice = is_jal ? 3'd3 : 3'd1;
                nxt       = FETCH;
            end
            default: nxt = FETCH;
        endcase
        // a frozen or resetting machine must never complete a partial write
        if (!go) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            rf_we   = 1'b0;
            dm_re   = 1'b0;
            dm_we   = 1'b0;
            set_ill = 1'b0;
        end
        if (rst) begin
            pc_choice = 3'd1;
            rf_wsel   = 3'd1;
            rf_dst    = 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= state_t'(RESET_STATE);
            ir      <= 32'd0;
            retired <= 32'd0;
            illegal <= 1'b0;
        end else begin
            if (ena)     cur     <= nxt;
            if (ir_we)   ir      <= instr;
            if (pc_we)   retired <= retired + 32'd1;
            if (set_ill) illegal <= 1'b1;
        end
    end
endmodule
